// File: rtl/msp430_pkg.sv
// Shared MSP430X writeback definitions: SR bit positions, special register
// numbers, the writeback state encoding and the destination width rule.
package msp430_pkg;

  localparam int SR_C   = 0;
  localparam int SR_Z   = 1;
  localparam int SR_N   = 2;
  localparam int SR_GIE = 3;
  localparam int SR_V   = 8;

  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_REG,
    ST_MEM_WR,
    ST_DONE
  } wb_state_t;

  // Byte ops keep the low byte, address-word ops keep all 20 bits, word ops 16.
  function automatic logic [19:0] width_rule(input logic [19:0] r,
                                             input logic bw,
                                             input logic aw);
    if (bw)
      return {12'h000, r[7:0]};
    else if (aw)
      return r;
    else
      return {4'h0, r[15:0]};
  endfunction

endpackage

// File: rtl/ex_writeback_if.sv
// Memory store bus between the writeback stage (master) and the data memory (slave).
interface ex_writeback_if;

  logic        mem_wr;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_bw;
  logic        mem_ready;

  modport master (
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    output mem_bw,
    input  mem_ready
  );

  modport slave (
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    input  mem_bw,
    output mem_ready
  );

endinterface

// File: rtl/wb_store_fsm.sv
// Store handshake for the writeback stage: holds the request until mem_ready,
// reports completion through DONE, or aborts with bus_err after MEM_TIMEOUT cycles.
module wb_store_fsm
  import msp430_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 MCLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [19:0]          addr,
  input  logic [15:0]          wdata,
  input  logic                 bw,
  ex_writeback_if.master       mem,
  output logic                 busy,
  output logic                 done,
  output logic                 bus_err
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mem_wr_reg, mem_wr_next;
  logic [19:0]      addr_reg, addr_next;
  logic [15:0]      wdata_reg, wdata_next;
  logic             bw_reg, bw_next;
  logic             bus_err_reg, bus_err_next;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      mem_wr_reg  <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      bw_reg      <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      mem_wr_reg  <= mem_wr_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      bw_reg      <= bw_next;
      bus_err_reg <= bus_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    mem_wr_next  = mem_wr_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    bw_next      = bw_reg;
    bus_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next  = ST_MEM_WR;
          cnt_next    = '0;
          mem_wr_next = 1'b1;
          // Word stores are forced onto an even address.
          addr_next   = {addr[19:1], addr[0] & bw};
          wdata_next  = wdata;
          bw_next     = bw;
        end
      end
      ST_MEM_WR: begin
        if (mem.mem_ready) begin
          state_next  = ST_DONE;
          mem_wr_next = 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = ST_IDLE;
          mem_wr_next  = 1'b0;
          bus_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign mem.mem_wr    = mem_wr_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign mem.mem_bw    = bw_reg;

  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign bus_err = bus_err_reg;

endmodule

// File: rtl/ex_writeback.sv
// Execute-stage commit: captures ALU result and flags, owns SR, and commits the
// result to the register file or, via wb_store_fsm, to memory.
module ex_writeback
  import msp430_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [15:0] SR_RESET    = 16'h0000
) (
  input  logic           MCLK,
  input  logic           reset,
  input  logic           wb_valid,
  output logic           wb_ready,
  input  logic [19:0]    result,
  input  logic           c_in,
  input  logic           v_in,
  input  logic           n_in,
  input  logic           z_in,
  input  logic           upd_flags,
  input  logic           dst_wr,
  input  logic           bw,
  input  logic           aw,
  input  logic           dst_is_reg,
  input  logic [3:0]     dst_reg,
  input  logic [19:0]    dst_addr,
  output logic           rf_we,
  output logic [3:0]     rf_waddr,
  output logic [19:0]    rf_wdata,
  ex_writeback_if.master mem,
  input  logic           sr_ld,
  input  logic [15:0]    sr_din,
  output logic [15:0]    sr,
  output logic           pc_load,
  output logic           done,
  output logic           bus_err
);

  wb_state_t   state_reg, state_next;
  logic [15:0] sr_reg, sr_next;
  logic        rf_we_reg, pc_load_reg;
  logic [3:0]  rf_waddr_reg;
  logic [19:0] rf_wdata_reg;
  logic [19:0] data_w;
  logic        accept, store_busy, store_done, store_start;
  logic        reg_path, reg_wr, r2_wr, pc_wr;

  assign wb_ready    = (state_reg == ST_IDLE) && !store_busy;
  assign accept      = wb_valid && wb_ready;
  assign data_w      = width_rule(result, bw, aw);
  assign reg_path    = accept && dst_wr && dst_is_reg;
  assign reg_wr      = reg_path && (dst_reg != REG_CG);
  assign r2_wr       = reg_path && (dst_reg == REG_SR);
  assign pc_wr       = reg_path && (dst_reg == REG_PC);
  assign store_start = accept && dst_wr && !dst_is_reg;

  always_ff @(posedge MCLK) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Stores are sequenced by wb_store_fsm; this FSM only covers the register/flag path.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept && !store_start) state_next = ST_WR_REG;
      ST_WR_REG: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      rf_we_reg    <= 1'b0;
      pc_load_reg  <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg   <= reg_wr;
      pc_load_reg <= pc_wr;
      if (reg_wr) begin
        rf_waddr_reg <= dst_reg;
        rf_wdata_reg <= pc_wr ? {data_w[19:1], 1'b0} : data_w;
      end
    end
  end

  // External load beats an R2 data write, which beats the ALU flag update.
  always_comb begin
    sr_next = sr_reg;
    if (sr_ld) begin
      sr_next = sr_din;
    end else if (r2_wr) begin
      sr_next = data_w[15:0];
    end else if (accept && upd_flags) begin
      sr_next[SR_C] = c_in;
      sr_next[SR_Z] = z_in;
      sr_next[SR_N] = n_in;
      sr_next[SR_V] = v_in;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset)
      sr_reg <= SR_RESET;
    else
      sr_reg <= sr_next;
  end

  wb_store_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_store (
    .MCLK    (MCLK),
    .reset   (reset),
    .start   (store_start),
    .addr    (dst_addr),
    .wdata   (data_w[15:0]),
    .bw      (bw),
    .mem     (mem),
    .busy    (store_busy),
    .done    (store_done),
    .bus_err (bus_err)
  );

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign pc_load  = pc_load_reg;
  assign sr       = sr_reg;
  assign done     = (state_reg == ST_WR_REG) || store_done;

endmodule

// File: tb/tb_ex_writeback.sv
// Scoreboard bench for ex_writeback: directed instructions push expected commits,
// a monitor pops and compares on every done/bus_err pulse.
module tb_ex_writeback;

  logic        MCLK = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ready;
  logic [19:0] result;
  logic        c_in, v_in, n_in, z_in;
  logic        upd_flags, dst_wr, bw, aw, dst_is_reg;
  logic [3:0]  dst_reg;
  logic [19:0] dst_addr;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [19:0] rf_wdata;
  logic        sr_ld;
  logic [15:0] sr_din;
  logic [15:0] sr;
  logic        pc_load, done, bus_err;

  ex_writeback_if m();

  ex_writeback #(.MEM_TIMEOUT(16), .SR_RESET(16'h0000)) dut (
    .MCLK(MCLK), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .result(result), .c_in(c_in), .v_in(v_in), .n_in(n_in), .z_in(z_in),
    .upd_flags(upd_flags), .dst_wr(dst_wr), .bw(bw), .aw(aw),
    .dst_is_reg(dst_is_reg), .dst_reg(dst_reg), .dst_addr(dst_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mem(m),
    .sr_ld(sr_ld), .sr_din(sr_din), .sr(sr), .pc_load(pc_load),
    .done(done), .bus_err(bus_err)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    string       name;
    logic        rf_we;
    logic [3:0]  waddr;
    logic [19:0] wdata;
    logic        pc_load;
    logic [15:0] sr;
    logic        bus_err;
    int          lat;
    int          memcnt;
    logic [19:0] maddr;
    logic [15:0] mdata;
    logic        mbw;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   ready_delay = 0;

  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Memory model: acknowledges after ready_delay request cycles.
  int rcnt = 0;
  always @(negedge MCLK) begin
    if (m.mem_wr === 1'b1) begin
      rcnt++;
      m.mem_ready = (rcnt > ready_delay);
    end else begin
      rcnt = 0;
      m.mem_ready = 1'b0;
    end
  end

  // Monitor: counts request cycles, captures the bus, checks each completion.
  int          memcnt = 0;
  logic [19:0] cap_addr = '0;
  logic [15:0] cap_data = '0;
  logic        cap_bw = 1'b0;
  exp_t        mon_e;
  always @(negedge MCLK) begin
    if (reset === 1'b1) begin
      memcnt = 0;
    end else begin
      if (m.mem_wr === 1'b1) begin
        memcnt++;
        cap_addr = m.mem_addr;
        cap_data = m.mem_wdata;
        cap_bw   = m.mem_bw;
      end
      if (done === 1'b1 || bus_err === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: done=%0b bus_err=%0b, required no completion", done, bus_err);
        end else begin
          mon_e = sb.pop_front();
          chk({mon_e.name, ".done"},    32'(done),    32'(!mon_e.bus_err));
          chk({mon_e.name, ".bus_err"}, 32'(bus_err), 32'(mon_e.bus_err));
          chk({mon_e.name, ".wb_ready"}, 32'(wb_ready), 32'(mon_e.bus_err));
          chk({mon_e.name, ".latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
          chk({mon_e.name, ".sr"},      32'(sr),      32'(mon_e.sr));
          chk({mon_e.name, ".rf_we"},   32'(rf_we),   32'(mon_e.rf_we));
          chk({mon_e.name, ".pc_load"}, 32'(pc_load), 32'(mon_e.pc_load));
          chk({mon_e.name, ".mem_cycles"}, 32'(memcnt), 32'(mon_e.memcnt));
          if (mon_e.rf_we) begin
            chk({mon_e.name, ".rf_waddr"}, 32'(rf_waddr), 32'(mon_e.waddr));
            chk({mon_e.name, ".rf_wdata"}, 32'(rf_wdata), 32'(mon_e.wdata));
          end
          if (mon_e.memcnt > 0) begin
            chk({mon_e.name, ".mem_addr"},  32'(cap_addr), 32'(mon_e.maddr));
            chk({mon_e.name, ".mem_wdata"}, 32'(cap_data), 32'(mon_e.mdata));
            chk({mon_e.name, ".mem_bw"},    32'(cap_bw),   32'(mon_e.mbw));
          end
          $display("commit %s: sr=%h rf_we=%0b waddr=%0d wdata=%h bus_err=%0b", mon_e.name, sr, rf_we, rf_waddr, rf_wdata, bus_err);
        end
        memcnt = 0;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge MCLK);
      if (wb_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: wb_ready=%0b, required 1 within 200 cycles", wb_ready);
    end
  endtask

  // cvnz = {c, v, n, z}
  task automatic run(input string nm, input logic [19:0] res, input logic [3:0] cvnz,
                     input logic upd, input logic dwr, input logic b, input logic a,
                     input logic isreg, input logic [3:0] dreg, input logic [19:0] daddr,
                     input logic ld, input logic [15:0] din, input int dly,
                     input logic e_we, input logic [19:0] e_wdata, input logic e_pc,
                     input logic [15:0] e_sr, input logic e_err, input int e_lat,
                     input int e_mc, input logic [19:0] e_maddr, input logic [15:0] e_mdata);
    exp_t e;
    bit   ok;
    result = res;
    {c_in, v_in, n_in, z_in} = cvnz;
    upd_flags = upd; dst_wr = dwr; bw = b; aw = a;
    dst_is_reg = isreg; dst_reg = dreg; dst_addr = daddr;
    wb_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      wb_valid = 1'b0;
      return;
    end
    sr_ld = ld; sr_din = din; ready_delay = dly;
    @(posedge MCLK);
    #1;
    wb_valid = 1'b0;
    sr_ld = 1'b0;
    e.name = nm; e.rf_we = e_we; e.waddr = dreg; e.wdata = e_wdata;
    e.pc_load = e_pc; e.sr = e_sr; e.bus_err = e_err; e.lat = e_lat;
    e.memcnt = e_mc; e.maddr = e_maddr; e.mdata = e_mdata; e.mbw = b; e.acc = cyc;
    sb.push_back(e);
  endtask

  initial begin
    bit ok;
    reset = 1'b1; wb_valid = 1'b0; result = '0;
    {c_in, v_in, n_in, z_in} = 4'b0000;
    upd_flags = 1'b0; dst_wr = 1'b0; bw = 1'b0; aw = 1'b0;
    dst_is_reg = 1'b0; dst_reg = '0; dst_addr = '0; sr_ld = 1'b0; sr_din = '0;
    repeat (3) @(posedge MCLK);
    #1;
    chk("reset.wb_ready", 32'(wb_ready), 32'd1);
    chk("reset.sr", 32'(sr), 32'h0000);
    chk("reset.rf_we", 32'(rf_we), 32'd0);
    chk("reset.rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset.rf_wdata", 32'(rf_wdata), 32'd0);
    chk("reset.mem_wr", 32'(m.mem_wr), 32'd0);
    chk("reset.mem_addr", 32'(m.mem_addr), 32'd0);
    chk("reset.mem_wdata", 32'(m.mem_wdata), 32'd0);
    chk("reset.mem_bw", 32'(m.mem_bw), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.pc_load", 32'(pc_load), 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    reset = 1'b0;

    //   name            result     cvnz   upd dwr bw aw reg dreg daddr     ld din       dly   we wdata      pc sr        err lat mc  maddr     mdata
    run("add_word",      20'h08000, 4'b0010, 1, 1, 0, 0, 1, 4'd5, 20'h0,     0, 16'h0,    0,    1, 20'h08000, 0, 16'h0004, 0, 1,  0,  20'h0,     16'h0);
    run("mov_byte",      20'hF12AB, 4'b0000, 0, 1, 1, 0, 1, 4'd6, 20'h0,     0, 16'h0,    0,    1, 20'h000AB, 0, 16'h0004, 0, 1,  0,  20'h0,     16'h0);
    run("mov_aword",     20'hF12AB, 4'b0000, 0, 1, 0, 1, 1, 4'd7, 20'h0,     0, 16'h0,    0,    1, 20'hF12AB, 0, 16'h0004, 0, 1,  0,  20'h0,     16'h0);
    run("byte_over_aw",  20'hF12AB, 4'b0000, 0, 1, 1, 1, 1, 4'd8, 20'h0,     0, 16'h0,    0,    1, 20'h000AB, 0, 16'h0004, 0, 1,  0,  20'h0,     16'h0);
    run("cmp_reg",       20'h12345, 4'b1001, 1, 0, 0, 0, 1, 4'd5, 20'h0,     0, 16'h0,    0,    0, 20'h0,     0, 16'h0003, 0, 1,  0,  20'h0,     16'h0);
    run("bit_mem",       20'h00F0F, 4'b0110, 1, 0, 0, 0, 0, 4'd0, 20'h00500, 0, 16'h0,    0,    0, 20'h0,     0, 16'h0104, 0, 1,  0,  20'h0,     16'h0);
    run("mov_pc",        20'h04401, 4'b0000, 0, 1, 0, 0, 1, 4'd0, 20'h0,     0, 16'h0,    0,    1, 20'h04400, 1, 16'h0104, 0, 1,  0,  20'h0,     16'h0);
    run("wr_sr",         20'h00108, 4'b1000, 1, 1, 0, 0, 1, 4'd2, 20'h0,     0, 16'h0,    0,    1, 20'h00108, 0, 16'h0108, 0, 1,  0,  20'h0,     16'h0);
    run("wr_cg",         20'h00FFF, 4'b0001, 1, 1, 0, 0, 1, 4'd3, 20'h0,     0, 16'h0,    0,    0, 20'h0,     0, 16'h000A, 0, 1,  0,  20'h0,     16'h0);
    run("store_word",    20'h0BEEF, 4'b0000, 0, 1, 0, 0, 0, 4'd0, 20'h00201, 0, 16'h0,    3,    0, 20'h0,     0, 16'h000A, 0, 5,  4,  20'h00200, 16'hBEEF);
    run("store_byte",    20'hF12C4, 4'b1010, 1, 1, 1, 0, 0, 4'd0, 20'h00305, 0, 16'h0,    0,    0, 20'h0,     0, 16'h000D, 0, 2,  1,  20'h00305, 16'h00C4);
    run("store_timeout", 20'h01234, 4'b0100, 1, 1, 0, 0, 0, 4'd0, 20'h00400, 0, 16'h0,    1000, 0, 20'h0,     0, 16'h0108, 1, 17, 16, 20'h00400, 16'h1234);
    run("srld_flags",    20'h00055, 4'b1111, 1, 1, 0, 0, 1, 4'd9, 20'h0,     1, 16'h0008, 0,    1, 20'h00055, 0, 16'h0008, 0, 1,  0,  20'h0,     16'h0);
    run("srld_r2",       20'h0FFFF, 4'b0000, 1, 1, 0, 0, 1, 4'd2, 20'h0,     1, 16'h0005, 0,    1, 20'h0FFFF, 0, 16'h0005, 0, 1,  0,  20'h0,     16'h0);

    // Reset in the second store cycle: request drops, SR returns to reset value.
    result = 20'h0AAAA; {c_in, v_in, n_in, z_in} = 4'b0000;
    upd_flags = 1'b0; dst_wr = 1'b1; bw = 1'b0; aw = 1'b0;
    dst_is_reg = 1'b0; dst_reg = '0; dst_addr = 20'h00600;
    wb_valid = 1'b1;
    wait_ready(ok);
    ready_delay = 1000;
    @(posedge MCLK);
    #1;
    wb_valid = 1'b0;
    @(posedge MCLK);
    #1;
    chk("rst_mem.mem_wr_before", 32'(m.mem_wr), 32'd1);
    reset = 1'b1;
    @(posedge MCLK);
    #1;
    chk("rst_mem.mem_wr", 32'(m.mem_wr), 32'd0);
    chk("rst_mem.sr", 32'(sr), 32'h0000);
    chk("rst_mem.wb_ready", 32'(wb_ready), 32'd1);
    chk("rst_mem.done", 32'(done), 32'd0);
    chk("rst_mem.bus_err", 32'(bus_err), 32'd0);
    $display("reset during store: mem_wr=%0b sr=%h wb_ready=%0b", m.mem_wr, sr, wb_ready);
    reset = 1'b0;

    run("post_reset",    20'h00077, 4'b0000, 0, 1, 0, 0, 1, 4'd4, 20'h0,     0, 16'h0,    0,    1, 20'h00077, 0, 16'h0000, 0, 1,  0,  20'h0,     16'h0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge MCLK);
    repeat (25) @(posedge MCLK);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d commits outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
